// File: rtl/stim_driver.sv
// rtl/stim_driver.sv - stimulus FIFO, issue pipeline and response checker for the t1/t2/t3 -> ff2 pipeline
module stim_driver #(
  parameter int DEPTH = 8,
  parameter int LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       hold,
  output logic       t1,
  output logic       t2,
  output logic       t3,
  input  logic       resp,
  output logic       out_valid,
  output logic [2:0] out_vec,
  output logic       out_resp,
  output logic       out_err,
  output logic       busy,
  output logic [7:0] done_cnt,
  output logic [7:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // One in-flight vector: valid flag, expected ff2 value and the driven {t3,t2,t1}
  typedef struct packed {
    logic       v;
    logic       exp;
    logic [2:0] vec;
  } tag_t;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          push;
  logic          pop;
  logic [3:0]    head;
  tag_t          tags [LAT];
  tag_t          last;
  logic          remain;
  state_t        state;
  state_t        state_nxt;

  assign in_ready = ~full_q;
  assign push     = in_valid & ~full_q;
  assign pop      = (count != '0) & ~hold;
  assign head     = mem[rptr];
  assign last     = tags[LAT-1];
  assign busy     = (state != IDLE);

  // Occupancy after this edge; push and pop together leave it unchanged
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_data;
    end
  end

  // Pointers, occupancy and the registered full flag that drives in_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      count  <= count_nxt;
      full_q <= (count_nxt == CW'(DEPTH));
    end
  end

  // Drive the popped vector (or a zero bubble) and shift its tag down the latency line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t1 <= 1'b0;
      t2 <= 1'b0;
      t3 <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        tags[i] <= '0;
      end
    end else begin
      t1 <= pop & head[0];
      t2 <= pop & head[1];
      t3 <= pop & head[2];
      tags[0] <= pop ? tag_t'{v: 1'b1, exp: head[3], vec: head[2:0]} : tag_t'('0);
      for (int i = 1; i < LAT; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  // Sample resp for the tag leaving the line and keep the running counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_vec   <= 3'b000;
      out_resp  <= 1'b0;
      out_err   <= 1'b0;
      done_cnt  <= 8'd0;
      err_cnt   <= 8'd0;
    end else begin
      out_valid <= last.v;
      out_err   <= last.v & (resp != last.exp);
      if (last.v) begin
        out_vec  <= last.vec;
        out_resp <= resp;
        done_cnt <= done_cnt + 8'd1;
        if ((resp != last.exp) && (err_cnt != 8'hff)) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

  // A valid tag is still in flight after this edge if one is being issued now
  // or sits in any stage other than the one completing now
  always_comb begin
    remain = pop;
    for (int i = 0; i < LAT - 1; i++) begin
      remain = remain | tags[i].v;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; hold only stops pops, it never steers the state machine
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (count == '0) begin
          state_nxt = remain ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (count != '0) begin
          state_nxt = RUN;
        end else if (!remain) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stim_driver.sv
// tb/tb_stim_driver.sv - table-driven self-checking bench for stim_driver
module tb_stim_driver;

  localparam int DEPTH = 8;
  localparam int LAT   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       hold = 1'b0;
  logic       in_ready;
  logic       t1, t2, t3;
  logic       resp;
  logic       out_valid;
  logic [2:0] out_vec;
  logic       out_resp;
  logic       out_err;
  logic       busy;
  logic [7:0] done_cnt;
  logic [7:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic force0 = 1'b0;
  logic ff2 = 1'b0;

  typedef struct {
    logic [3:0] din;
    logic [2:0] vec;
    logic       rsp;
    logic       err;
  } vec_t;

  typedef struct {
    logic [2:0] vec;
    logic       rsp;
    logic       err;
    logic [7:0] dc;
    logic [7:0] ec;
    int         cyc;
  } cmp_t;

  vec_t tbl [8];
  cmp_t q [$];
  logic [3:0] hv [4];

  stim_driver #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .hold(hold),
    .t1(t1), .t2(t2), .t3(t3),
    .resp(resp),
    .out_valid(out_valid), .out_vec(out_vec), .out_resp(out_resp), .out_err(out_err),
    .busy(busy), .done_cnt(done_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pipeline model: the DUT's t register is the first stage, ff2 = (t1 & t2) | t3 the second
  always @(posedge clk) ff2 <= (t1 & t2) | t3;
  assign resp = force0 ? 1'b0 : ff2;

  // Completion monitor
  always @(negedge clk) begin
    if (rst && out_valid) begin
      q.push_back('{out_vec, out_resp, out_err, done_cnt, err_cnt, cyc});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] d);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL push_wait: in_ready stuck at 0 for data %0d", d);
    end else begin
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              din       vec     rsp   err       f = (t1&t2)|t3
    tbl[0] = '{4'b1_101, 3'b101, 1'b1, 1'b0};
    tbl[1] = '{4'b0_011, 3'b011, 1'b1, 1'b1};
    tbl[2] = '{4'b0_010, 3'b010, 1'b0, 1'b0};
    tbl[3] = '{4'b1_100, 3'b100, 1'b1, 1'b0};
    tbl[4] = '{4'b1_001, 3'b001, 1'b0, 1'b1};
    tbl[5] = '{4'b0_000, 3'b000, 1'b0, 1'b0};
    tbl[6] = '{4'b0_111, 3'b111, 1'b1, 1'b1};
    tbl[7] = '{4'b1_110, 3'b110, 1'b1, 1'b0};
    hv[0] = 4'b1_111;
    hv[1] = 4'b0_010;
    hv[2] = 4'b1_101;
    hv[3] = 4'b1_011;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready_during", in_ready, 1);
    chk("rst_busy_during", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_t", {t3, t2, t1}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_out_valid", out_valid, 0);

    // Single vector: pushed at edge k, driven from k+1, completes at k+3
    push(4'b1_101);
    @(negedge clk);
    chk("single_no_bypass", {t3, t2, t1}, 0);
    chk("single_busy_idle", busy, 0);
    @(negedge clk);
    chk("single_t", {t3, t2, t1}, 3'b101);
    chk("single_busy", busy, 1);
    chk("single_early_valid", out_valid, 0);
    @(negedge clk);
    chk("single_bubble", {t3, t2, t1}, 0);
    chk("single_early_valid2", out_valid, 0);
    @(negedge clk);
    chk("single_out_valid", out_valid, 1);
    chk("single_out_vec", out_vec, 3'b101);
    chk("single_out_resp", out_resp, 1);
    chk("single_out_err", out_err, 0);
    chk("single_done_cnt", done_cnt, 1);
    chk("single_err_cnt", err_cnt, 0);
    chk("single_busy_fall", busy, 0);
    @(negedge clk);
    chk("single_pulse_width", out_valid, 0);

    // Fill under hold, then stream the table
    q.delete();
    hold = 1'b1;
    for (int i = 0; i < 8; i++) push(tbl[i].din);
    @(negedge clk);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_no_issue", {t3, t2, t1}, 0);
    chk("fill_busy", busy, 1);
    hold = 1'b0;
    @(negedge clk);
    chk("fill_ready_back", in_ready, 1);
    chk("fill_first_t", {t3, t2, t1}, tbl[0].vec);
    wait_idle("fill");
    chk("fill_count", q.size(), 8);
    if (q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("fill_vec%0d", i), q[i].vec, tbl[i].vec);
        chk($sformatf("fill_rsp%0d", i), q[i].rsp, tbl[i].rsp);
        chk($sformatf("fill_err%0d", i), q[i].err, tbl[i].err);
        if (i > 0) chk($sformatf("fill_gap%0d", i), q[i].cyc - q[i-1].cyc, 1);
      end
    end
    chk("fill_done_cnt", done_cnt, 9);
    chk("fill_err_cnt", err_cnt, 3);

    // Hold mid-stream: three bubbles between the 2nd and 3rd issue
    q.delete();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(hv[i]);
    @(negedge clk);
    hold = 1'b0;
    @(negedge clk);
    chk("hold_t0", {t3, t2, t1}, hv[0][2:0]);
    @(negedge clk);
    chk("hold_t1", {t3, t2, t1}, hv[1][2:0]);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold_bubble%0d", i), {t3, t2, t1}, 0);
      chk($sformatf("hold_busy%0d", i), busy, 1);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("hold_t2", {t3, t2, t1}, hv[2][2:0]);
    wait_idle("hold");
    chk("hold_count", q.size(), 4);
    if (q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("hold_vec%0d", i), q[i].vec, hv[i][2:0]);
        chk($sformatf("hold_err%0d", i), q[i].err, 0);
      end
    end
    chk("hold_done_cnt", done_cnt, 13);

    // Mismatch and saturation from fresh counters
    do_reset();
    @(negedge clk);
    chk("sat_rst_done", done_cnt, 0);
    chk("sat_rst_err", err_cnt, 0);
    q.delete();
    force0 = 1'b1;
    for (int i = 0; i < 260; i++) push(4'b1_011);
    wait_idle("sat");
    force0 = 1'b0;
    chk("sat_count", q.size(), 260);
    if (q.size() == 260) begin
      chk("sat_err_all", q[0].err & q[127].err & q[255].err & q[259].err, 1);
      chk("sat_ec_253", q[253].ec, 254);
      chk("sat_ec_254", q[254].ec, 255);
      chk("sat_ec_259", q[259].ec, 255);
      chk("sat_dc_255", q[255].dc, 0);
    end
    chk("sat_err_cnt", err_cnt, 255);
    chk("sat_done_cnt", done_cnt, 4);

    // Reset mid-run: 3 words queued, 2 in flight
    hold = 1'b1;
    for (int i = 0; i < 5; i++) push(4'b1_111);
    q.delete();
    @(negedge clk);
    hold = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    hold = 1'b1;
    rst  = 1'b0;
    #1;
    chk("mid_t", {t3, t2, t1}, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_vec", out_vec, 0);
    chk("mid_out_resp", out_resp, 0);
    chk("mid_out_err", out_err, 0);
    chk("mid_done_cnt", done_cnt, 0);
    chk("mid_err_cnt", err_cnt, 0);
    chk("mid_busy", busy, 0);
    chk("mid_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    hold = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_no_valid", q.size(), 0);
    chk("mid_after_busy", busy, 0);
    chk("mid_after_done", done_cnt, 0);
    chk("mid_after_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
